// File: rtl/mat_mult_seq.sv
// -----------------------------------------------------------------------------
// mat_mult_seq
// Sequencing controller for a 5x5 signed 8-bit matrix multiply, C = A x B.
// On start it snapshots A and B. It then walks the 25 result positions in
// row-major order. For each position it presents one row of A and one column
// of B to an external combinational inner-product unit, and writes the 8-bit
// result returned by that unit into C one cycle later. A sticky overflow flag
// is accumulated across the whole operation. Completion is a one-cycle done
// pulse.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous reset, active low
//   start      request a multiply; sampled only while idle
//   mat_a      matrix A, element (r,c) at [8*(5r+c) +: 8], two's complement
//   mat_b      matrix B, same packing as mat_a
//   lin_out    row i of A;    slot k at [8k +: 8] = A(i,k)
//   col_out    column j of B; slot k at [8k +: 8] = B(k,j)
//   ip_result  inner product of the current lin_out/col_out
//   ip_ovf     overflow flag of the current inner product
//   mat_c      result matrix, same packing as mat_a
//   busy       high while an operation is in progress
//   done       one-cycle pulse when mat_c is complete
//   ovf        sticky OR of ip_ovf over the current operation
// -----------------------------------------------------------------------------
module mat_mult_seq #(
  parameter int DIM = 5,  // only 5 is supported (40-bit vector interface)
  parameter int W   = 8   // only 8 is supported
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DIM*DIM*W-1:0] mat_a,
  input  logic [DIM*DIM*W-1:0] mat_b,
  output logic [DIM*W-1:0]     lin_out,
  output logic [DIM*W-1:0]     col_out,
  input  logic [W-1:0]         ip_result,
  input  logic                 ip_ovf,
  output logic [DIM*DIM*W-1:0] mat_c,
  output logic                 busy,
  output logic                 done,
  output logic                 ovf
);

  localparam int MW = DIM * DIM * W;
  localparam int VW = DIM * W;
  localparam int IW = $clog2(DIM);
  localparam int NW = $clog2(DIM * DIM);
  localparam logic [IW-1:0] LAST_RC = IW'(DIM - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [MW-1:0]  a_q, a_d;          // snapshot of mat_a
  logic [MW-1:0]  b_q, b_d;          // snapshot of mat_b
  logic [MW-1:0]  c_q, c_d;          // result matrix
  logic [VW-1:0]  lin_q, lin_d;
  logic [VW-1:0]  col_q, col_d;
  logic [IW-1:0]  iss_row_q, iss_row_d;  // issue position (i,j)
  logic [IW-1:0]  iss_col_q, iss_col_d;
  logic [NW-1:0]  wb_idx_q, wb_idx_d;    // writeback position, 0..24
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           ovf_q, ovf_d;

  logic last_issue;
  logic wb_fire;

  assign last_issue = (iss_row_q == LAST_RC) && (iss_col_q == LAST_RC);

  // Writeback trails issue by one cycle: the first RUN cycle (issue position
  // still at (0,0)) has nothing to write yet, and DRAIN writes the last one.
  assign wb_fire = (state_q == S_DRAIN) ||
                   ((state_q == S_RUN) && ((iss_row_q != '0) || (iss_col_q != '0)));

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential blocks use non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start)      state_d = S_RUN;
      S_RUN:   if (last_issue) state_d = S_DRAIN;
      S_DRAIN:                 state_d = S_IDLE;
      default:                 state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM output / datapath next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every *_d gets its hold value first, so no path through this
    // block leaves a variable unassigned and no latch is inferred.
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    lin_d     = lin_q;
    col_d     = col_q;
    iss_row_d = iss_row_q;
    iss_col_d = iss_col_q;
    wb_idx_d  = wb_idx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ovf_d     = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d       = mat_a;
          b_d       = mat_b;
          c_d       = '0;
          ovf_d     = 1'b0;
          iss_row_d = '0;
          iss_col_d = '0;
          wb_idx_d  = '0;
          busy_d    = 1'b1;
        end
      end

      S_RUN: begin
        for (int k = 0; k < DIM; k++) begin
          lin_d[k*W +: W] = a_q[(int'(iss_row_q) * DIM + k) * W +: W];
          col_d[k*W +: W] = b_q[(k * DIM + int'(iss_col_q)) * W +: W];
        end
        // The issue position parks on (4,4) once the last pair is out.
        if (!last_issue) begin
          if (iss_col_q == LAST_RC) begin
            iss_col_d = '0;
            iss_row_d = iss_row_q + 1'b1;
          end else begin
            iss_col_d = iss_col_q + 1'b1;
          end
        end
      end

      S_DRAIN: begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end

      default: ;
    endcase

    // The inner-product unit is combinational on lin_q/col_q, so ip_result
    // belongs to the position issued on the previous edge.
    if (wb_fire) begin
      c_d[int'(wb_idx_q) * W +: W] = ip_result;
      ovf_d = ovf_q | ip_ovf;
      // DRAIN writes position 24; the counter stays there.
      if (state_q == S_RUN) wb_idx_d = wb_idx_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the operand snapshots are plain flops, not a RAM, so clearing
      // them on reset is cheap and keeps lin_out/col_out deterministic.
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      lin_q     <= '0;
      col_q     <= '0;
      iss_row_q <= '0;
      iss_col_q <= '0;
      wb_idx_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      lin_q     <= lin_d;
      col_q     <= col_d;
      iss_row_q <= iss_row_d;
      iss_col_q <= iss_col_d;
      wb_idx_q  <= wb_idx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
    end
  end

  assign lin_out = lin_q;
  assign col_out = col_q;
  assign mat_c   = c_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_mat_mult_seq.sv
// -----------------------------------------------------------------------------
// tb_mat_mult_seq
// Bench for mat_mult_seq. A behavioural inner-product unit closes the loop
// on lin_out/col_out. Each accepted start pushes its hand-derived result
// onto a scoreboard queue; a monitor pops and compares on every done pulse.
// Stimulus: identity, constant fills, mixed-sign wrap cases, start/operand
// disturbance mid-run, reset mid-run and back-to-back operations.
// -----------------------------------------------------------------------------
module tb_mat_mult_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [199:0] mat_a, mat_b;
  logic [39:0]  lin_out, col_out;
  logic [7:0]   ip_result;
  logic         ip_ovf;
  logic [199:0] mat_c;
  logic         busy, done, ovf;

  always #5 clk = ~clk;

  mat_mult_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mat_a     (mat_a),
    .mat_b     (mat_b),
    .lin_out   (lin_out),
    .col_out   (col_out),
    .ip_result (ip_result),
    .ip_ovf    (ip_ovf),
    .mat_c     (mat_c),
    .busy      (busy),
    .done      (done),
    .ovf       (ovf)
  );

  // Combinational 5-element inner-product unit: wrapped 8-bit sum, with
  // overflow when the exact sum does not fit in signed 8 bits.
  int ip_sum;
  always_comb begin
    ip_sum = 0;
    for (int k = 0; k < 5; k++)
      ip_sum = ip_sum + int'($signed(lin_out[k*8 +: 8])) * int'($signed(col_out[k*8 +: 8]));
    ip_result = ip_sum[7:0];
    ip_ovf    = (ip_sum > 127) || (ip_sum < -128);
  end

  // ---------------------------------------------------------------------------
  // Scoreboard and bookkeeping
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [199:0] c;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  int   n_vec    = 0;
  int   n_err    = 0;
  int   done_cnt = 0;

  task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [199:0] c, input logic o);
    exp_t e;
    e.c   = c;
    e.ovf = o;
    sb.push_back(e);
  endtask

  // ---------------------------------------------------------------------------
  // Matrix builders
  // ---------------------------------------------------------------------------
  function automatic logic [199:0] fill(input logic [7:0] v);
    logic [199:0] m;
    for (int e = 0; e < 25; e++) m[e*8 +: 8] = v;
    return m;
  endfunction

  function automatic logic [199:0] ident();
    logic [199:0] m;
    m = '0;
    for (int r = 0; r < 5; r++) m[(r*5 + r)*8 +: 8] = 8'h01;
    return m;
  endfunction

  // B(r,c) = 5r + c - 12
  function automatic logic [199:0] ramp();
    logic [199:0] m;
    for (int e = 0; e < 25; e++) m[e*8 +: 8] = 8'(e - 12);
    return m;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor: compare on every done pulse
  // ---------------------------------------------------------------------------
  initial begin
    bit   prev_done;
    exp_t e;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_cnt++;
        check("done_single_cycle", 200'(prev_done), 200'(0));
        check("done_expected", 200'(sb.size() != 0), 200'(1));
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("mat_c", mat_c, e.c);
          check("ovf", 200'(ovf), 200'(e.ovf));
        end
      end
      prev_done = done;
    end
  end

  // ---------------------------------------------------------------------------
  // One operation: start, optional start/mat_a poke at cycle poke_cycle,
  // then wait for done and check latency and busy duration.
  // ---------------------------------------------------------------------------
  task automatic run_op(input logic [199:0] a, input logic [199:0] b,
                        input logic [199:0] exp_c, input logic exp_ovf,
                        input int poke_cycle, input logic [199:0] poke_a);
    int n;
    int busy_n;
    bit seen;
    @(negedge clk);
    mat_a = a;
    mat_b = b;
    start = 1'b1;
    push_exp(exp_c, exp_ovf);
    n      = 0;
    busy_n = 0;
    seen   = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1) seen = 1'b1;
      if (n == poke_cycle) begin
        start = 1'b1;
        mat_a = poke_a;
      end else begin
        start = 1'b0;
      end
    end
    check("done_seen", 200'(seen), 200'(1));
    check("latency_edges", 200'(n - 1), 200'(26));
    check("busy_cycles", 200'(busy_n), 200'(26));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_lin_out"}, 200'(lin_out), 200'(0));
    check({tag, "_col_out"}, 200'(col_out), 200'(0));
    check({tag, "_mat_c"},   mat_c,         200'(0));
    check({tag, "_busy"},    200'(busy),    200'(0));
    check({tag, "_done"},    200'(done),    200'(0));
    check({tag, "_ovf"},     200'(ovf),     200'(0));
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [199:0] m1_a, m1_b, m1_c, m2_a, m2_b, m2_c;
  int           d0, n, seen;

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    mat_a = '0;
    mat_b = '0;

    // Mixed-sign vectors: C(0,0) = -128 exactly, then -128 - 1 wraps to 0x7F.
    m1_a = '0; m1_a[7:0]   = 8'h80;
    m1_b = '0; m1_b[7:0]   = 8'h01;
    m1_c = '0; m1_c[7:0]   = 8'h80;
    m2_a = m1_a; m2_a[15:8]  = 8'hFF;   // A(0,1) = -1
    m2_b = m1_b; m2_b[47:40] = 8'h01;   // B(1,0) = 1
    m2_c = '0; m2_c[7:0]   = 8'h7F;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;

    // Identity x ramp gives the ramp back.
    run_op(ident(), ramp(), ramp(), 1'b0, -1, '0);
    // 2*2*5 = 20
    run_op(fill(8'h02), fill(8'h02), fill(8'h14), 1'b0, -1, '0);
    // 10*10*5 = 500 -> 0xF4, overflow
    run_op(fill(8'h0A), fill(8'h0A), fill(8'hF4), 1'b1, -1, '0);
    run_op(m1_a, m1_b, m1_c, 1'b0, -1, '0);
    run_op(m2_a, m2_b, m2_c, 1'b1, -1, '0);

    // start pulse and new mat_a at cycle 10: result must match the 2x2 run.
    d0 = done_cnt;
    run_op(fill(8'h02), fill(8'h02), fill(8'h14), 1'b0, 10, fill(8'h0A));
    repeat (30) @(negedge clk);
    check("restart_single_done", 200'(done_cnt - d0), 200'(1));

    // Reset at cycle 12 of a run: everything clears, no done.
    @(negedge clk);
    mat_a = fill(8'h0A);
    mat_b = fill(8'h0A);
    start = 1'b1;
    push_exp(fill(8'hF4), 1'b1);
    repeat (12) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("pre_reset_ovf", 200'(ovf), 200'(1));
    rst = 1'b0;
    sb.delete();
    d0 = done_cnt;
    @(negedge clk);
    check_all_zero("midrun_reset");
    rst = 1'b1;
    repeat (30) @(negedge clk);
    check("no_done_after_reset", 200'(done_cnt - d0), 200'(0));
    run_op(fill(8'h0A), fill(8'h0A), fill(8'hF4), 1'b1, -1, '0);

    // Back-to-back: start held high across done launches a second operation.
    @(negedge clk);
    mat_a = ident();
    mat_b = ramp();
    start = 1'b1;
    push_exp(ramp(), 1'b0);
    n = 0;
    seen = 0;
    while (seen == 0 && n < 100) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) seen = 1;
    end
    check("b2b_first_done_seen", 200'(seen), 200'(1));
    check("b2b_first_latency", 200'(n - 1), 200'(26));
    mat_a = m2_a;
    mat_b = m2_b;
    push_exp(m2_c, 1'b1);
    @(negedge clk);
    start = 1'b0;
    check("b2b_mat_c_cleared", mat_c, 200'(0));
    check("b2b_busy", 200'(busy), 200'(1));
    n = 1;
    seen = 0;
    while (seen == 0 && n < 100) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) seen = 1;
    end
    check("b2b_second_done_seen", 200'(seen), 200'(1));
    check("b2b_second_latency", 200'(n - 1), 200'(26));

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 200'(sb.size()), 200'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog timeout");
  end

endmodule
